// File: rtl/ioctl_cfg_pkg.sv
// Shared types and constants for the ioctl configuration loader.
package ioctl_cfg_pkg;

  localparam int unsigned ADDR_W = 25;

  localparam logic [7:0] ROM_INDEX = 8'd0;
  localparam logic [7:0] MOD_INDEX = 8'd1;
  localparam logic [7:0] DIP_INDEX = 8'd254;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSettle,
    StReady
  } ldr_state_e;

endpackage

// File: rtl/ioctl_cfg_loader_if.sv
// Download bus from hps_io: master drives it, the loader consumes it as slave.
interface ioctl_cfg_loader_if;
  import ioctl_cfg_pkg::*;

  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
  );

  modport slave (
    input ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
  );

endinterface

// File: rtl/ioctl_region_decode.sv
// Combinational priority decoder: maps a ROM stream address to a one-hot region
// select and a region-relative address.
module ioctl_region_decode
  import ioctl_cfg_pkg::*;
#(
  parameter int unsigned                    NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
    {25'h0C000, 25'h08000, 25'h04000, 25'h0},
  parameter logic [ADDR_W-1:0]              ROM_SIZE    = 25'h10000
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic [NUM_REGIONS-1:0] sel,
  output logic [ADDR_W-1:0]      rel_addr,
  output logic                   in_range
);

  logic [ADDR_W-1:0]      base_sel;
  logic [NUM_REGIONS-1:0] hit_oh;

  // Bases ascend, so the last matching region in the scan is the highest one.
  always_comb begin
    base_sel = '0;
    hit_oh   = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (addr >= REGION_BASE[k*ADDR_W +: ADDR_W]) begin
        base_sel  = REGION_BASE[k*ADDR_W +: ADDR_W];
        hit_oh    = '0;
        hit_oh[k] = 1'b1;
      end
    end
    in_range = (addr < ROM_SIZE);
    sel      = in_range ? hit_oh : '0;
    rel_addr = addr - base_sel;
  end

endmodule

// File: rtl/ioctl_cfg_loader.sv
// DIP/mod capture, ROM region write gating and core reset sequencing.
// Optional IOCTL_CFG_CHECKSUM_EN adds a 16-bit additive sum of loaded ROM bytes.
module ioctl_cfg_loader
  import ioctl_cfg_pkg::*;
#(
  parameter int unsigned                    NUM_DIP     = 8,
  parameter int unsigned                    NUM_MOD     = 4,
  parameter int unsigned                    NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
    {25'h0C000, 25'h08000, 25'h04000, 25'h0},
  parameter logic [ADDR_W-1:0]              ROM_SIZE    = 25'h10000,
  parameter int unsigned                    RESET_HOLD  = 16,
  parameter logic [7:0]                     DIP_DEFAULT = 8'hFF
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  ioctl_cfg_loader_if.slave      io,
  input  logic                   flip_req,
  output logic [NUM_DIP*8-1:0]   dip_sw,
  output logic [NUM_MOD*8-1:0]   mod_bytes,
  output logic                   mod_orientation,
  output logic [NUM_REGIONS-1:0] rom_wr,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic                   core_reset,
  output logic                   rom_loaded,
  output logic                   rom_overflow,
`ifdef IOCTL_CFG_CHECKSUM_EN
  output logic [15:0]            rom_sum,
`endif
  output logic [ADDR_W-1:0]      dl_bytes
);

  localparam int unsigned CntW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  ldr_state_e             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NUM_DIP*8-1:0]   dip_q;
  logic [NUM_MOD*8-1:0]   mod_q;
  logic                   orient_q;
  logic [NUM_REGIONS-1:0] rom_wr_q;
  logic [ADDR_W-1:0]      rom_addr_q;
  logic [7:0]             rom_data_q;
  logic                   overflow_q;
  logic [ADDR_W-1:0]      dl_q;
`ifdef IOCTL_CFG_CHECKSUM_EN
  logic [15:0]            sum_q;
`endif

  logic [NUM_REGIONS-1:0] dec_sel;
  logic [ADDR_W-1:0]      dec_rel;
  logic                   dec_in_range;
  logic                   dip_we, mod_we, rom_we, load_entry;

  ioctl_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .ROM_SIZE    (ROM_SIZE)
  ) u_decode (
    .addr     (io.ioctl_addr),
    .sel      (dec_sel),
    .rel_addr (dec_rel),
    .in_range (dec_in_range)
  );

  assign dip_we     = io.ioctl_wr && (io.ioctl_index == DIP_INDEX);
  assign mod_we     = io.ioctl_wr && (io.ioctl_index == MOD_INDEX);
  assign rom_we     = (state_q == StLoad) && io.ioctl_wr && (io.ioctl_index == ROM_INDEX);
  assign load_entry = (state_q != StLoad) && (state_d == StLoad);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StReady: begin
        if (io.ioctl_download && (io.ioctl_index == ROM_INDEX)) state_d = StLoad;
      end
      StLoad: begin
        if (!io.ioctl_download) begin
          state_d = StSettle;
          cnt_d   = CntW'(RESET_HOLD - 1);
        end
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StReady;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Configuration capture runs regardless of loader state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dip_q    <= {NUM_DIP{DIP_DEFAULT}};
      mod_q    <= '0;
      orient_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_DIP; k++) begin
        if (dip_we && (io.ioctl_addr == ADDR_W'(k))) dip_q[8*k +: 8] <= io.ioctl_dout;
      end
      for (int k = 0; k < NUM_MOD; k++) begin
        if (mod_we && (io.ioctl_addr == ADDR_W'(k))) mod_q[8*k +: 8] <= io.ioctl_dout;
      end
      orient_q <= mod_q[0] ^ flip_req;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rom_wr_q   <= '0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      overflow_q <= 1'b0;
      dl_q       <= '0;
`ifdef IOCTL_CFG_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      rom_wr_q <= '0;
      if (load_entry) begin
        overflow_q <= 1'b0;
        dl_q       <= '0;
`ifdef IOCTL_CFG_CHECKSUM_EN
        sum_q      <= '0;
`endif
      end else if (rom_we) begin
        if (!(&dl_q)) dl_q <= dl_q + ADDR_W'(1);
        if (dec_in_range) begin
          rom_wr_q   <= dec_sel;
          rom_addr_q <= dec_rel;
          rom_data_q <= io.ioctl_dout;
`ifdef IOCTL_CFG_CHECKSUM_EN
          sum_q      <= sum_q + {8'h00, io.ioctl_dout};
`endif
        end else begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  assign dip_sw          = dip_q;
  assign mod_bytes       = mod_q;
  assign mod_orientation = orient_q;
  assign rom_wr          = rom_wr_q;
  assign rom_addr        = rom_addr_q;
  assign rom_data        = rom_data_q;
  assign core_reset      = (state_q != StReady);
  assign rom_loaded      = (state_q == StReady);
  assign rom_overflow    = overflow_q;
  assign dl_bytes        = dl_q;
`ifdef IOCTL_CFG_CHECKSUM_EN
  assign rom_sum         = sum_q;
`endif

endmodule

// File: tb/tb_ioctl_cfg_loader.sv
// Randomised self-checking bench for ioctl_cfg_loader against a transaction-level model.
module tb_ioctl_cfg_loader;

  localparam int unsigned NUM_DIP     = 8;
  localparam int unsigned NUM_MOD     = 4;
  localparam int unsigned NUM_REGIONS = 4;
  localparam int unsigned RESET_HOLD  = 16;
  localparam logic [24:0] ROM_SIZE    = 25'h10000;
  localparam logic [24:0] BASES [NUM_REGIONS] = '{25'h0, 25'h4000, 25'h8000, 25'hC000};

  logic clk_sys = 1'b0;
  logic reset;
  logic flip_req;
  logic [NUM_DIP*8-1:0]   dip_sw;
  logic [NUM_MOD*8-1:0]   mod_bytes;
  logic                   mod_orientation;
  logic [NUM_REGIONS-1:0] rom_wr;
  logic [24:0]            rom_addr;
  logic [7:0]             rom_data;
  logic                   core_reset, rom_loaded, rom_overflow;
  logic [24:0]            dl_bytes;
`ifdef IOCTL_CFG_CHECKSUM_EN
  logic [15:0]            rom_sum;
`endif

  ioctl_cfg_loader_if io ();

  ioctl_cfg_loader #(
    .NUM_DIP     (NUM_DIP),
    .NUM_MOD     (NUM_MOD),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE ({25'h0C000, 25'h08000, 25'h04000, 25'h0}),
    .ROM_SIZE    (ROM_SIZE),
    .RESET_HOLD  (RESET_HOLD),
    .DIP_DEFAULT (8'hFF)
  ) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .io              (io),
    .flip_req        (flip_req),
    .dip_sw          (dip_sw),
    .mod_bytes       (mod_bytes),
    .mod_orientation (mod_orientation),
    .rom_wr          (rom_wr),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .core_reset      (core_reset),
    .rom_loaded      (rom_loaded),
    .rom_overflow    (rom_overflow),
`ifdef IOCTL_CFG_CHECKSUM_EN
    .rom_sum         (rom_sum),
`endif
    .dl_bytes        (dl_bytes)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0]  m_dip [NUM_DIP];
  logic [7:0]  m_mod [NUM_MOD];
  logic [24:0] m_addr, m_dl;
  logic [7:0]  m_data;
  logic        m_ovf;
  logic [15:0] m_sum;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [63:0] dip_flat();
    logic [63:0] v = '0;
    for (int k = 0; k < NUM_DIP; k++) v[8*k +: 8] = m_dip[k];
    return v;
  endfunction

  function automatic logic [63:0] mod_flat();
    logic [63:0] v = '0;
    for (int k = 0; k < NUM_MOD; k++) v[8*k +: 8] = m_mod[k];
    return v;
  endfunction

  function automatic int region_of(input logic [24:0] a);
    for (int k = NUM_REGIONS - 1; k >= 0; k--) if (a >= BASES[k]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_DIP; k++) m_dip[k] = 8'hFF;
    for (int k = 0; k < NUM_MOD; k++) m_mod[k] = 8'h00;
    m_addr = '0; m_data = '0; m_ovf = 1'b0; m_dl = '0; m_sum = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".dip"}, 64'(dip_sw), 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq({tag, ".mod"}, 64'(mod_bytes), 64'h0);
    check_eq({tag, ".orient"}, 64'(mod_orientation), 64'h0);
    check_eq({tag, ".rom_wr"}, 64'(rom_wr), 64'h0);
    check_eq({tag, ".rom_addr"}, 64'(rom_addr), 64'h0);
    check_eq({tag, ".rom_data"}, 64'(rom_data), 64'h0);
    check_eq({tag, ".core_reset"}, 64'(core_reset), 64'h1);
    check_eq({tag, ".rom_loaded"}, 64'(rom_loaded), 64'h0);
    check_eq({tag, ".overflow"}, 64'(rom_overflow), 64'h0);
    check_eq({tag, ".dl_bytes"}, 64'(dl_bytes), 64'h0);
`ifdef IOCTL_CFG_CHECKSUM_EN
    check_eq({tag, ".rom_sum"}, 64'(rom_sum), 64'h0);
`endif
  endtask

  // One-cycle config write; model applies it if the address is in range.
  task automatic cfg_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    io.ioctl_wr = 1'b1; io.ioctl_index = idx; io.ioctl_addr = a; io.ioctl_dout = d;
    step();
    io.ioctl_wr = 1'b0;
    if (idx == 8'd254 && a < NUM_DIP) m_dip[a] = d;
    if (idx == 8'd1 && a < NUM_MOD) m_mod[a] = d;
    check_eq("dip_sw", 64'(dip_sw), dip_flat());
    check_eq("mod_bytes", 64'(mod_bytes), mod_flat());
  endtask

  task automatic start_load();
    io.ioctl_download = 1'b1; io.ioctl_index = 8'd0;
    step();
    m_dl = '0; m_ovf = 1'b0; m_sum = '0;
    check_eq("load.core_reset", 64'(core_reset), 64'h1);
    check_eq("load.rom_loaded", 64'(rom_loaded), 64'h0);
    check_eq("load.dl_bytes", 64'(dl_bytes), 64'h0);
    check_eq("load.overflow", 64'(rom_overflow), 64'h0);
`ifdef IOCTL_CFG_CHECKSUM_EN
    check_eq("load.rom_sum", 64'(rom_sum), 64'h0);
`endif
  endtask

  task automatic rom_write(input logic [24:0] a, input logic [7:0] d);
    logic [NUM_REGIONS-1:0] exp_wr;
    int k;
    io.ioctl_wr = 1'b1; io.ioctl_index = 8'd0; io.ioctl_addr = a; io.ioctl_dout = d;
    step();
    io.ioctl_wr = 1'b0;
    exp_wr = '0;
    if (m_dl != 25'h1FF_FFFF) m_dl = m_dl + 25'd1;
    if (a < ROM_SIZE) begin
      k = region_of(a);
      exp_wr[k] = 1'b1;
      m_addr = a - BASES[k];
      m_data = d;
      m_sum  = m_sum + 16'(d);
    end else begin
      m_ovf = 1'b1;
    end
    check_eq("rom_wr", 64'(rom_wr), 64'(exp_wr));
    check_eq("rom_addr", 64'(rom_addr), 64'(m_addr));
    check_eq("rom_data", 64'(rom_data), 64'(m_data));
    check_eq("dl_bytes", 64'(dl_bytes), 64'(m_dl));
    check_eq("rom_overflow", 64'(rom_overflow), 64'(m_ovf));
`ifdef IOCTL_CFG_CHECKSUM_EN
    check_eq("rom_sum", 64'(rom_sum), 64'(m_sum));
`endif
  endtask

  task automatic idle_check_strobe();
    step();
    check_eq("rom_wr.idle", 64'(rom_wr), 64'h0);
  endtask

  // End download with a last write in the fall cycle, then time the reset hold.
  task automatic end_load(input logic [24:0] a, input logic [7:0] d);
    io.ioctl_download = 1'b0;
    rom_write(a, d);
    check_eq("settle.core_reset[0]", 64'(core_reset), 64'h1);
    for (int i = 1; i < RESET_HOLD; i++) begin
      step();
      check_eq($sformatf("settle.core_reset[%0d]", i), 64'(core_reset), 64'h1);
      check_eq("settle.rom_loaded", 64'(rom_loaded), 64'h0);
    end
    step();
    check_eq("ready.core_reset", 64'(core_reset), 64'h0);
    check_eq("ready.rom_loaded", 64'(rom_loaded), 64'h1);
  endtask

  initial begin
    logic [7:0] idx_pick;
    logic       f;
    reset = 1'b1; flip_req = 1'b0;
    io.ioctl_download = 1'b0; io.ioctl_wr = 1'b0; io.ioctl_addr = '0;
    io.ioctl_dout = '0; io.ioctl_index = '0;
    model_reset();
    repeat (3) step();
    check_reset_state("reset");
    reset = 1'b0;
    step();

    // DIP directed writes, then randomised config traffic on several indices
    cfg_write(8'd254, 25'd0, 8'h3C);
    cfg_write(8'd254, 25'd1, 8'hA5);
    cfg_write(8'd254, 25'd9, 8'h00);
    check_eq("dip.directed", 64'(dip_sw), 64'hFFFF_FFFF_FFFF_A53C);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       idx_pick = 8'd254;
        1:       idx_pick = 8'd1;
        default: idx_pick = 8'd7;
      endcase
      cfg_write(idx_pick, 25'($urandom_range(0, 11)), 8'($urandom));
    end

    // Orientation: mod write lags 2 cycles, flip_req lags 1
    cfg_write(8'd1, 25'd0, 8'h00);
    step(); step();
    check_eq("orient.base", 64'(mod_orientation), 64'h0);
    cfg_write(8'd1, 25'd0, 8'h01);
    check_eq("orient.lag1", 64'(mod_orientation), 64'h0);
    step();
    check_eq("orient.lag2", 64'(mod_orientation), 64'h1);
    flip_req = 1'b1;
    step();
    check_eq("orient.flip", 64'(mod_orientation), 64'h0);
    for (int i = 0; i < 10; i++) begin
      f = 1'($urandom);
      flip_req = f;
      step();
      check_eq("orient.rand", 64'(mod_orientation), 64'(f ^ 1'b1));
    end
    flip_req = 1'b0;

    // First ROM load: directed strobes, overflow, random traffic, timed settle
    start_load();
    rom_write(25'h3FFF, 8'h11);
    idle_check_strobe();
    rom_write(25'h4000, 8'h22);
    idle_check_strobe();
    rom_write(25'hC005, 8'h33);
    idle_check_strobe();
    check_eq("dl_bytes.3", 64'(dl_bytes), 64'd3);
    rom_write(25'h10000, 8'h44);
    check_eq("overflow.set", 64'(rom_overflow), 64'h1);
    for (int i = 0; i < 30; i++) begin
      rom_write(25'($urandom_range(0, 25'h10FFF)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle_check_strobe();
    end
    idle_check_strobe();
    end_load(25'h7FFF, 8'h5E);

    // Non-ROM download must not disturb the loader
    io.ioctl_download = 1'b1; io.ioctl_index = 8'd254;
    step();
    cfg_write(8'd254, 25'd2, 8'h77);
    io.ioctl_download = 1'b0;
    step();
    check_eq("dipdl.core_reset", 64'(core_reset), 64'h0);
    check_eq("dipdl.rom_loaded", 64'(rom_loaded), 64'h1);
    check_eq("dipdl.dl_bytes", 64'(dl_bytes), 64'(m_dl));

    // Second load clears overflow; checksum bytes; then reset mid-load
    start_load();
    rom_write(25'h0100, 8'hFF);
    rom_write(25'h0101, 8'hFF);
    rom_write(25'h0102, 8'h02);
`ifdef IOCTL_CFG_CHECKSUM_EN
    check_eq("rom_sum.0200", 64'(rom_sum), 64'h0200);
`endif
    reset = 1'b1;
    step();
    model_reset();
    check_reset_state("midreset");
    reset = 1'b0;
    step();
    rom_write(25'h8001, 8'h5A);
    check_eq("reenter.rom_wr", 64'(rom_wr), 64'b0100);
    idle_check_strobe();
    end_load(25'h0003, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
